// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the 3x3 convolution window generator.
package conv_pkg;

    localparam int unsigned KERNEL_TAPS = 9;
    localparam int unsigned KERNEL_DIM  = 3;

    // Legacy-compatible state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 3x3 window stream out.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_CH  = 3
);
    localparam int unsigned PIX_W = IN_CH * DATA_W;
    localparam int unsigned WIN_W = PIX_W * KERNEL_TAPS;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] pix_in;
    logic             window_valid;
    logic [WIN_W-1:0] window_out;
    logic             frame_done;

    modport master (
        output in_valid, pix_in,
        input  in_ready, window_valid, window_out, frame_done
    );

    modport slave (
        input  in_valid, pix_in,
        output in_ready, window_valid, window_out, frame_done
    );
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One row of pixels for one channel: combinational read, write on accepted beat.
module line_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Storage: cleared on reset, written at the current column
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 sliding windows (valid padding, all channels).
// Optional CONV_WIN_STRIDE2_EN: emit only windows anchored on even row/col.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_CH  = 3,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input logic             clk,
    input logic             rst,
    conv_window_gen_if.slave bus
);
    localparam int unsigned PIX_W = IN_CH * DATA_W;
    localparam int unsigned WIN_W = PIX_W * KERNEL_TAPS;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_ready_q;
    logic             window_valid_q;
    logic [WIN_W-1:0] window_out_q;
    logic             frame_done_q;

    logic             accept_c;
    logic             col_last_c;
    logic             last_pix_c;
    logic             emit_c;

    logic [DATA_W-1:0] pix_ch [IN_CH];
    logic [DATA_W-1:0] rd_r1  [IN_CH];
    logic [DATA_W-1:0] rd_r2  [IN_CH];
    logic [DATA_W-1:0] win_q  [IN_CH][KERNEL_DIM][KERNEL_DIM];
    logic [DATA_W-1:0] win_d  [IN_CH][KERNEL_DIM][KERNEL_DIM];
    logic [WIN_W-1:0]  win_flat_c;

    assign accept_c   = bus.in_valid & in_ready_q;
    assign col_last_c = (col == COL_W'(IMG_W - 1));
    assign last_pix_c = accept_c && col_last_c && (row == ROW_W'(IMG_H - 1));

`ifdef CONV_WIN_STRIDE2_EN
    assign emit_c = accept_c && (row >= ROW_W'(2)) && (col >= COL_W'(2)) && !row[0] && !col[0];
`else
    assign emit_c = accept_c && (row >= ROW_W'(2)) && (col >= COL_W'(2));
`endif

    assign bus.in_ready     = in_ready_q;
    assign bus.window_valid = window_valid_q;
    assign bus.window_out   = window_out_q;
    assign bus.frame_done   = frame_done_q;

    // Per channel: row r-1 buffer feeds row r-2 buffer at the same column
    for (genvar c = 0; c < int'(IN_CH); c++) begin : g_ch
        assign pix_ch[c] = bus.pix_in[(int'(IN_CH) - c) * int'(DATA_W) - 1 -: DATA_W];

        line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb_r1 (
            .clk   (clk),
            .rst   (rst),
            .we    (accept_c),
            .addr  (col),
            .wdata (pix_ch[c]),
            .rdata (rd_r1[c])
        );

        line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb_r2 (
            .clk   (clk),
            .rst   (rst),
            .we    (accept_c),
            .addr  (col),
            .wdata (rd_r1[c]),
            .rdata (rd_r2[c])
        );
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_c)   state_next = ST_RUN;
            ST_RUN:  if (last_pix_c) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Raster position of the next beat; cleared when the frame completes
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept_c) begin
            if (last_pix_c) begin
                col <= '0;
                row <= '0;
            end else if (col_last_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Shift window left and append the new column (oldest row on top), then pack
    always_comb begin
        win_flat_c = '0;
        for (int c = 0; c < int'(IN_CH); c++) begin
            for (int r = 0; r < int'(KERNEL_DIM); r++) begin
                win_d[c][r][0] = win_q[c][r][1];
                win_d[c][r][1] = win_q[c][r][2];
            end
            win_d[c][0][2] = rd_r2[c];
            win_d[c][1][2] = rd_r1[c];
            win_d[c][2][2] = pix_ch[c];
            for (int r = 0; r < int'(KERNEL_DIM); r++) begin
                for (int k = 0; k < int'(KERNEL_DIM); k++) begin
                    win_flat_c[(int'(IN_CH * KERNEL_TAPS) - (c * int'(KERNEL_TAPS) + r * 3 + k))
                               * int'(DATA_W) - 1 -: DATA_W] = win_d[c][r][k];
                end
            end
        end
    end

    // Shift window advances only on accepted beats
    always_ff @(posedge clk) begin
        if (rst)           win_q <= '{default: '0};
        else if (accept_c) win_q <= win_d;
    end

    // Registered outputs; window_out holds between valid windows
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q     <= 1'b1;
            window_valid_q <= 1'b0;
            window_out_q   <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            in_ready_q     <= (state_next != ST_DONE);
            window_valid_q <= emit_c;
            frame_done_q   <= (state_next == ST_DONE);
            if (emit_c) window_out_q <= win_flat_c;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen; build with CONV_WIN_STRIDE2_EN for the stride-2 case.
module tb_conv_window_gen;
`ifdef CONV_WIN_STRIDE2_EN
    localparam int IN_CH = 3;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
`else
    localparam int IN_CH = 1;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
`endif
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int N_WIN = 4;
    localparam int PIX_W = IN_CH * 8;
    localparam int WIN_W = PIX_W * 9;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [WIN_W-1:0] win_q [$];
    int               win_cyc_q [$];
    logic [1:0]       fd_q [$];
    logic [WIN_W-1:0] last_out;
    bit               hold_en;
    int               acc_cyc [64];
    int               br_list [N_WIN];

    conv_window_gen_if #(.DATA_W(8), .IN_CH(IN_CH)) bus ();

    conv_window_gen #(.DATA_W(8), .IN_CH(IN_CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int p, input int c);
        return 8'(p + 64 * c);
    endfunction

    function automatic logic [PIX_W-1:0] pix_word(input int p);
        logic [PIX_W-1:0] w;
        w = '0;
        for (int c = 0; c < IN_CH; c++) w[(IN_CH - c) * 8 - 1 -: 8] = pix_val(p, c);
        return w;
    endfunction

    // Expected window from the raster index of its bottom-right tap
    function automatic logic [WIN_W-1:0] exp_win(input int br);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int c = 0; c < IN_CH; c++)
            for (int t = 0; t < 9; t++)
                w[(IN_CH * 9 - (c * 9 + t)) * 8 - 1 -: 8] =
                    pix_val(br - (2 - t / 3) * IMG_W - (2 - t % 3), c);
        return w;
    endfunction

    // Output monitor
    always @(negedge clk) begin
        if (bus.window_valid === 1'b1) begin
            win_q.push_back(bus.window_out);
            win_cyc_q.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) fd_q.push_back({bus.window_valid, bus.in_ready});
        if (hold_en && bus.window_valid === 1'b0) check("hold", 256'(bus.window_out), 256'(last_out));
        last_out = bus.window_out;
    end

    task automatic send_frame(input int n, input bit bubbles);
        int g;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            if (bubbles && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.pix_in   = pix_word(p);
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) check("ready_timeout", 256'(0), 256'(1));
            @(posedge clk);
            #1;
            acc_cyc[p] = cyc;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        win_q.delete();
        win_cyc_q.delete();
        fd_q.delete();
    endtask

    task automatic verify_frame(input string tag);
        check({tag, "_nwin"}, 256'(win_q.size()), 256'(N_WIN));
        for (int i = 0; i < N_WIN; i++) begin
            if (i < win_q.size()) begin
                check($sformatf("%s_win%0d", tag, i), 256'(win_q[i]), 256'(exp_win(br_list[i])));
                check($sformatf("%s_lat%0d", tag, i), 256'(win_cyc_q[i]), 256'(acc_cyc[br_list[i]]));
            end
        end
        check({tag, "_nfd"}, 256'(fd_q.size()), 256'(1));
        if (fd_q.size() > 0) check({tag, "_fd_valid_ready"}, 256'(fd_q[0]), 256'(2'b10));
        clear_obs();
    endtask

    initial begin
`ifdef CONV_WIN_STRIDE2_EN
        br_list = '{12, 14, 22, 24};
`else
        br_list = '{10, 11, 14, 15};
`endif
        hold_en      = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.pix_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_window_valid", 256'(bus.window_valid), 256'(0));
        check("rst_frame_done",   256'(bus.frame_done),   256'(0));
        check("rst_window_out",   256'(bus.window_out),   256'(0));
        check("rst_in_ready",     256'(bus.in_ready),     256'(1));
        rst = 1'b0;
        @(negedge clk);
        hold_en = 1'b1;
        clear_obs();

        // Back-to-back frame
        send_frame(N_PIX, 1'b0);
        repeat (6) @(negedge clk);
`ifndef CONV_WIN_STRIDE2_EN
        if (win_q.size() > 0) check("first_win_const", 256'(win_q[0]), 256'(72'h00_01_02_04_05_06_08_09_0a));
`endif
        verify_frame("basic");

        // Same frame with random bubbles, then a second identical frame
        send_frame(N_PIX, 1'b1);
        repeat (6) @(negedge clk);
        verify_frame("bubble");
        send_frame(N_PIX, 1'b0);
        repeat (6) @(negedge clk);
        verify_frame("second");

        // Abort after pixel 9, then a fresh frame
        send_frame(10, 1'b0);
        hold_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_nwin", 256'(win_q.size()), 256'(0));
        check("abort_nfd",  256'(fd_q.size()),  256'(0));
        check("abort_out",  256'(bus.window_out), 256'(0));
        hold_en = 1'b1;
        clear_obs();
        send_frame(N_PIX, 1'b0);
        repeat (6) @(negedge clk);
        verify_frame("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per pixel per channel.
REQ-002 SHALL have parameter IN_CH, default 3: input channels per pixel.
REQ-003 SHALL have parameter IMG_W, default 32: frame width in pixels, legal range 3 or more.
REQ-004 SHALL have parameter IMG_H, default 32: frame height in pixels, legal range 3 or more.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: pixel beat offered.
REQ-008 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port pix_in, input, IN_CH*DATA_W bits: one raster-order pixel; channel 0 in the MSBs.
REQ-010 SHALL have port window_valid, output, 1 bit: one-cycle qualifier for window_out.
REQ-011 SHALL have port window_out, output, IN_CH*DATA_W*9 bits: 3x3 window for every channel, feeding the convolution stage.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-013 SHALL run a state machine with three states: IDLE, RUN, DONE.
REQ-014 SHALL move from IDLE to RUN on the first accepted beat, and SHALL process that beat.
REQ-015 SHALL move from RUN to DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-016 SHALL move from DONE to IDLE unconditionally after one cycle.
REQ-017 SHALL drive in_ready high in IDLE and RUN, and low in DONE only.
REQ-018 SHALL keep col and row counters, each $clog2 of its dimension wide.
REQ-019 SHALL advance col on each accepted beat; col SHALL wrap from IMG_W-1 to 0 and then increment row.
REQ-020 SHALL clear both counters when entering DONE.
REQ-021 SHALL hold two line buffers per channel, each IMG_W deep, holding rows r-1 and r-2, plus a 3x3 shift window per channel.
REQ-022 SHALL update the line buffers and shift window only on accepted beats; idle cycles leave all state unchanged.
REQ-023 SHALL register window_valid high exactly one cycle after acceptance of a pixel with row>=2 and col>=2 (valid padding, no border windows).
REQ-024 SHALL NOT assert window_valid for a window that spans the row wrap.
REQ-025 SHALL define tap t = 3*r+k, where r=0 is the oldest row and k=0 the leftmost column.
REQ-026 SHALL place channel c, tap t at window_out bits [(IN_CH*9-(c*9+t))*DATA_W-1 -: DATA_W], so channel 0 tap 0 occupies the MSBs.
REQ-027 SHALL hold window_out stable when window_valid is low.
REQ-028 SHALL pass pixel data through unmodified, with no arithmetic.
REQ-029 SHALL assert frame_done in the DONE cycle, which is one cycle after the last beat and coincides with the last window_valid.

Reset
REQ-030 SHALL, on rst high at a clock edge, set state IDLE, counters 0, window_valid 0, frame_done 0, window_out 0 and in_ready 1.
REQ-031 SHALL clear line-buffer contents on reset; stale data SHALL never be emitted, because window_valid is gated by the counters.
REQ-032 SHALL treat rst mid-frame as an abort; the next accepted beat is pixel (0,0) of a new frame.

Configuration
REQ-033 SHALL support macro CONV_WIN_STRIDE2_EN.
REQ-034 SHALL, when CONV_WIN_STRIDE2_EN is defined, assert window_valid only when row>=2, col>=2 and both row and col are even (stride 2), giving ((IMG_W-3)/2+1)*((IMG_H-3)/2+1) windows per frame.
REQ-035 SHALL, when CONV_WIN_STRIDE2_EN is undefined, use stride 1, giving (IMG_W-2)*(IMG_H-2) windows per frame.

Structure
REQ-036 SHALL take the constant KERNEL_TAPS=9 and state encodings IDLE/RUN/DONE from shared package conv_pkg.
REQ-037 SHALL instantiate sub-module line_buffer (DATA_W-wide, IMG_W-deep, write-enable per beat) once per channel per row, 2*IN_CH instances in total.

Verification
REQ-038 SHALL cover reset: hold rst for 3 cycles -> window_valid=0, frame_done=0, window_out=0, in_ready=1.
REQ-039 SHALL cover a basic frame: IN_CH=1, IMG_W=IMG_H=4, pixels 0..15 back-to-back -> 4 windows; the first appears 1 cycle after pixel 10 with taps 0,1,2,4,5,6,8,9,10; the last has taps 5,6,7,9,10,11,13,14,15.
REQ-040 SHALL cover bubbles: the same frame with in_valid low on random cycles -> identical 4 windows in order, and no extra window_valid.
REQ-041 SHALL cover frame boundary: after pixel 15 -> frame_done pulse with the last window and in_ready low for one cycle; a second identical frame then yields identical windows.
REQ-042 SHALL cover reset mid-frame: rst after pixel 9 -> no window; a new frame 0..15 -> exactly 4 correct windows.
REQ-043 SHALL cover stride 2: with CONV_WIN_STRIDE2_EN defined, IMG_W=IMG_H=5, pixels 0..24 -> 4 windows, with bottom-right taps 12, 14, 22 and 24; IN_CH=3 -> channel 0 data in the MSBs.
